// File: rtl/operand_collector_alu_if.sv
// Bus bundles around the operand collector: issue handoff, register-file read
// port and ALU dispatch. Signal names match the surrounding pipeline.

interface oc_issue_if;
    logic        Valid_Issue_OC;
    logic [2:0]  WarpID_Issue_OC;
    logic [7:0]  ActiveMask_Issue_OC;
    logic [31:0] Instr_Issue_OC;
    logic [4:0]  Src1_Issue_OC;
    logic        Src1_Valid_Issue_OC;
    logic [4:0]  Src2_Issue_OC;
    logic        Src2_Valid_Issue_OC;
    logic [4:0]  Dst_Issue_OC;
    logic [15:0] Imme_Issue_OC;
    logic        Imme_Valid_Issue_OC;
    logic        RegWrite_Issue_OC;
    logic [3:0]  ALUop_Issue_OC;
    logic        BEQ_Issue_OC;
    logic        BLT_Issue_OC;
    logic [1:0]  ScbID_Issue_OC;
    logic        Ready_OC_Issue;

    modport master (
        output Valid_Issue_OC, WarpID_Issue_OC, ActiveMask_Issue_OC, Instr_Issue_OC,
               Src1_Issue_OC, Src1_Valid_Issue_OC, Src2_Issue_OC, Src2_Valid_Issue_OC,
               Dst_Issue_OC, Imme_Issue_OC, Imme_Valid_Issue_OC, RegWrite_Issue_OC,
               ALUop_Issue_OC, BEQ_Issue_OC, BLT_Issue_OC, ScbID_Issue_OC,
        input  Ready_OC_Issue
    );

    modport slave (
        input  Valid_Issue_OC, WarpID_Issue_OC, ActiveMask_Issue_OC, Instr_Issue_OC,
               Src1_Issue_OC, Src1_Valid_Issue_OC, Src2_Issue_OC, Src2_Valid_Issue_OC,
               Dst_Issue_OC, Imme_Issue_OC, Imme_Valid_Issue_OC, RegWrite_Issue_OC,
               ALUop_Issue_OC, BEQ_Issue_OC, BLT_Issue_OC, ScbID_Issue_OC,
        output Ready_OC_Issue
    );
endinterface

interface oc_rf_if;
    logic         Req_OC_RF;
    logic [2:0]   WarpID_OC_RF;
    logic [4:0]   Addr_OC_RF;
    logic         Grant_RF_OC;
    logic [255:0] Data_RF_OC;

    modport master (
        output Req_OC_RF, WarpID_OC_RF, Addr_OC_RF,
        input  Grant_RF_OC, Data_RF_OC
    );

    modport slave (
        input  Req_OC_RF, WarpID_OC_RF, Addr_OC_RF,
        output Grant_RF_OC, Data_RF_OC
    );
endinterface

interface oc_alu_if;
    logic         Valid_OC_ALU;
    logic [7:0]   ActiveMask_OC_ALU;
    logic [2:0]   WarpID_OC_ALU;
    logic [31:0]  Instr_OC_ALU;
    logic [255:0] Src1_Data_OC_ALU;
    logic [255:0] Src2_Data_OC_ALU;
    logic [4:0]   Dst_OC_ALU;
    logic [15:0]  Imme_OC_ALU;
    logic         Imme_Valid_OC_ALU;
    logic         RegWrite_OC_ALU;
    logic [3:0]   ALUop_OC_ALU;
    logic         BEQ_OC_ALU;
    logic         BLT_OC_ALU;
    logic [1:0]   ScbID_OC_ALU;

    modport master (
        output Valid_OC_ALU, ActiveMask_OC_ALU, WarpID_OC_ALU, Instr_OC_ALU,
               Src1_Data_OC_ALU, Src2_Data_OC_ALU, Dst_OC_ALU, Imme_OC_ALU,
               Imme_Valid_OC_ALU, RegWrite_OC_ALU, ALUop_OC_ALU, BEQ_OC_ALU,
               BLT_OC_ALU, ScbID_OC_ALU
    );

    modport slave (
        input  Valid_OC_ALU, ActiveMask_OC_ALU, WarpID_OC_ALU, Instr_OC_ALU,
               Src1_Data_OC_ALU, Src2_Data_OC_ALU, Dst_OC_ALU, Imme_OC_ALU,
               Imme_Valid_OC_ALU, RegWrite_OC_ALU, ALUop_OC_ALU, BEQ_OC_ALU,
               BLT_OC_ALU, ScbID_OC_ALU
    );
endinterface

// File: rtl/operand_collector_alu.sv
// Single-entry operand collector: latches one issued instruction, reads up to two
// source registers through a shared RF port, then dispatches it to the ALU.

module operand_collector_alu (
    input  logic      clk,
    input  logic      rst,
    oc_issue_if.slave issue,
    oc_rf_if.master   rf,
    oc_alu_if.master  alu
);

    typedef enum logic [2:0] {
        IDLE,
        RD1,
        CAP1,
        RD2,
        CAP2,
        DISP
    } state_t;

    state_t state;
    state_t state_nxt;

    logic         ready;
    logic         req;
    logic [4:0]   addr;
    logic         transfer;
    logic         need1_in;
    logic         need2_in;

    logic [2:0]   warp_q;
    logic [7:0]   mask_q;
    logic [31:0]  instr_q;
    logic [4:0]   src1_q;
    logic [4:0]   src2_q;
    logic         need2_q;
    logic [4:0]   dst_q;
    logic [15:0]  imme_q;
    logic         imme_v_q;
    logic         regwrite_q;
    logic [3:0]   aluop_q;
    logic         beq_q;
    logic         blt_q;
    logic [1:0]   scb_q;
    logic [255:0] src1_data_q;
    logic [255:0] src2_data_q;

    // Register 0 is hard-wired to zero, so it never costs an RF read.
    assign need1_in = issue.Src1_Valid_Issue_OC && (issue.Src1_Issue_OC != '0);
    assign need2_in = issue.Src2_Valid_Issue_OC && (issue.Src2_Issue_OC != '0);
    assign transfer = issue.Valid_Issue_OC && ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        req       = 1'b0;
        addr      = src1_q;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (issue.Valid_Issue_OC) begin
                    if (need1_in) begin
                        state_nxt = RD1;
                    end else if (need2_in) begin
                        state_nxt = RD2;
                    end else begin
                        state_nxt = DISP;
                    end
                end
            end
            RD1: begin
                req  = 1'b1;
                addr = src1_q;
                if (rf.Grant_RF_OC) begin
                    state_nxt = CAP1;
                end
            end
            CAP1: begin
                state_nxt = need2_q ? RD2 : DISP;
            end
            RD2: begin
                req  = 1'b1;
                addr = src2_q;
                if (rf.Grant_RF_OC) begin
                    state_nxt = CAP2;
                end
            end
            CAP2: begin
                state_nxt = DISP;
            end
            DISP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign issue.Ready_OC_Issue = ready;
    assign rf.Req_OC_RF         = req;
    assign rf.Addr_OC_RF        = addr;
    assign rf.WarpID_OC_RF      = warp_q;

    // Entry storage; source buffers restart at zero so skipped reads dispatch zeros.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            warp_q      <= '0;
            mask_q      <= '0;
            instr_q     <= '0;
            src1_q      <= '0;
            src2_q      <= '0;
            need2_q     <= 1'b0;
            dst_q       <= '0;
            imme_q      <= '0;
            imme_v_q    <= 1'b0;
            regwrite_q  <= 1'b0;
            aluop_q     <= '0;
            beq_q       <= 1'b0;
            blt_q       <= 1'b0;
            scb_q       <= '0;
            src1_data_q <= '0;
            src2_data_q <= '0;
        end else if (transfer) begin
            warp_q      <= issue.WarpID_Issue_OC;
            mask_q      <= issue.ActiveMask_Issue_OC;
            instr_q     <= issue.Instr_Issue_OC;
            src1_q      <= issue.Src1_Issue_OC;
            src2_q      <= issue.Src2_Issue_OC;
            need2_q     <= need2_in;
            dst_q       <= issue.Dst_Issue_OC;
            imme_q      <= issue.Imme_Issue_OC;
            imme_v_q    <= issue.Imme_Valid_Issue_OC;
            regwrite_q  <= issue.RegWrite_Issue_OC;
            aluop_q     <= issue.ALUop_Issue_OC;
            beq_q       <= issue.BEQ_Issue_OC;
            blt_q       <= issue.BLT_Issue_OC;
            scb_q       <= issue.ScbID_Issue_OC;
            src1_data_q <= '0;
            src2_data_q <= '0;
        end else if (state == CAP1) begin
            src1_data_q <= rf.Data_RF_OC;
        end else if (state == CAP2) begin
            src2_data_q <= rf.Data_RF_OC;
        end
    end

    // ALU-side registers load only in DISP and otherwise hold their last values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu.Valid_OC_ALU      <= 1'b0;
            alu.ActiveMask_OC_ALU <= '0;
            alu.WarpID_OC_ALU     <= '0;
            alu.Instr_OC_ALU      <= '0;
            alu.Src1_Data_OC_ALU  <= '0;
            alu.Src2_Data_OC_ALU  <= '0;
            alu.Dst_OC_ALU        <= '0;
            alu.Imme_OC_ALU       <= '0;
            alu.Imme_Valid_OC_ALU <= 1'b0;
            alu.RegWrite_OC_ALU   <= 1'b0;
            alu.ALUop_OC_ALU      <= '0;
            alu.BEQ_OC_ALU        <= 1'b0;
            alu.BLT_OC_ALU        <= 1'b0;
            alu.ScbID_OC_ALU      <= '0;
        end else begin
            alu.Valid_OC_ALU <= (state == DISP);
            if (state == DISP) begin
                alu.ActiveMask_OC_ALU <= mask_q;
                alu.WarpID_OC_ALU     <= warp_q;
                alu.Instr_OC_ALU      <= instr_q;
                alu.Src1_Data_OC_ALU  <= src1_data_q;
                alu.Src2_Data_OC_ALU  <= src2_data_q;
                alu.Dst_OC_ALU        <= dst_q;
                alu.Imme_OC_ALU       <= imme_q;
                alu.Imme_Valid_OC_ALU <= imme_v_q;
                alu.RegWrite_OC_ALU   <= regwrite_q;
                alu.ALUop_OC_ALU      <= aluop_q;
                alu.BEQ_OC_ALU        <= beq_q;
                alu.BLT_OC_ALU        <= blt_q;
                alu.ScbID_OC_ALU      <= scb_q;
            end
        end
    end

endmodule

// File: tb/tb_operand_collector_alu.sv
// Scoreboard bench for operand_collector_alu: a behavioural RF answers read
// requests with a known pattern; each dispatch is checked against its queued entry.

module tb_operand_collector_alu;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    oc_issue_if issue_bus ();
    oc_rf_if    rf_bus ();
    oc_alu_if   alu_bus ();

    operand_collector_alu dut (
        .clk   (clk),
        .rst   (rst),
        .issue (issue_bus.slave),
        .rf    (rf_bus.master),
        .alu   (alu_bus.master)
    );

    typedef struct {
        logic [2:0]  w;
        logic [7:0]  mask;
        logic [31:0] instr;
        logic [4:0]  s1;
        logic        s1v;
        logic [4:0]  s2;
        logic        s2v;
        logic [4:0]  dst;
        logic [15:0] imm;
        logic        immv;
        logic        regw;
        logic [3:0]  aluop;
        logic        beq;
        logic        blt;
        logic [1:0]  scb;
    } op_t;

    typedef struct {
        op_t          o;
        logic [255:0] d1;
        logic [255:0] d2;
        int           lat;
    } txn_t;

    txn_t sb[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;

    int grant_delay = 0;
    bit simple_data = 1'b0;
    int waited = 0;
    logic [2:0] gnt_warp = '0;
    logic [4:0] gnt_addr = '0;
    logic [4:0] req_addr_log[$];
    logic [2:0] req_warp_log[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [255:0] rf_word(input logic [2:0] w, input logic [4:0] a);
        logic [255:0] r;
        for (int k = 0; k < 8; k++) begin
            r[k*32 +: 32] = simple_data ? 32'(k) : {8'(w), 8'(a), 8'hC5, 8'(k)};
        end
        return r;
    endfunction

    // Behavioural RF: optional grant stall, data valid the cycle after grant, poison otherwise.
    initial begin
        rf_bus.Grant_RF_OC = 1'b0;
        rf_bus.Data_RF_OC  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rf_bus.Grant_RF_OC) rf_bus.Data_RF_OC = rf_word(gnt_warp, gnt_addr);
            else                    rf_bus.Data_RF_OC = {8{32'hDEAD_BEEF}};
            if (rf_bus.Req_OC_RF) begin
                req_addr_log.push_back(rf_bus.Addr_OC_RF);
                req_warp_log.push_back(rf_bus.WarpID_OC_RF);
                if (waited < grant_delay) begin
                    waited++;
                    rf_bus.Grant_RF_OC = 1'b0;
                end else begin
                    rf_bus.Grant_RF_OC = 1'b1;
                    gnt_warp    = rf_bus.WarpID_OC_RF;
                    gnt_addr    = rf_bus.Addr_OC_RF;
                    waited      = 0;
                    grant_delay = 0;
                end
            end else begin
                rf_bus.Grant_RF_OC = 1'b0;
                waited = 0;
            end
        end
    end

    function automatic op_t rand_op();
        op_t o;
        o.w = 3'($urandom);      o.mask = 8'($urandom);   o.instr = $urandom;
        o.s1 = 5'($urandom);     o.s1v = 1'($urandom);    o.s2 = 5'($urandom);
        o.s2v = 1'($urandom);    o.dst = 5'($urandom);    o.imm = 16'($urandom);
        o.immv = 1'($urandom);   o.regw = 1'($urandom);   o.aluop = 4'($urandom);
        o.beq = 1'($urandom);    o.blt = 1'($urandom);    o.scb = 2'($urandom);
        return o;
    endfunction

    function automatic txn_t expect_of(input op_t o, input int delay);
        txn_t t;
        int reads;
        reads = 0;
        t.o  = o;
        t.d1 = '0;
        t.d2 = '0;
        if (o.s1v && o.s1 != 5'd0) begin t.d1 = rf_word(o.w, o.s1); reads++; end
        if (o.s2v && o.s2 != 5'd0) begin t.d2 = rf_word(o.w, o.s2); reads++; end
        t.lat = 1 + 2 * reads + ((reads > 0) ? delay : 0);
        return t;
    endfunction

    function automatic logic [73:0] exp_ctrl(input op_t o);
        return {o.w, o.mask, o.instr, o.dst, o.imm, o.immv, o.regw, o.aluop, o.beq, o.blt, o.scb};
    endfunction

    function automatic logic [73:0] dut_ctrl();
        return {alu_bus.WarpID_OC_ALU, alu_bus.ActiveMask_OC_ALU, alu_bus.Instr_OC_ALU,
                alu_bus.Dst_OC_ALU, alu_bus.Imme_OC_ALU, alu_bus.Imme_Valid_OC_ALU,
                alu_bus.RegWrite_OC_ALU, alu_bus.ALUop_OC_ALU, alu_bus.BEQ_OC_ALU,
                alu_bus.BLT_OC_ALU, alu_bus.ScbID_OC_ALU};
    endfunction

    task automatic drive_op(input op_t o);
        issue_bus.WarpID_Issue_OC     = o.w;
        issue_bus.ActiveMask_Issue_OC = o.mask;
        issue_bus.Instr_Issue_OC      = o.instr;
        issue_bus.Src1_Issue_OC       = o.s1;
        issue_bus.Src1_Valid_Issue_OC = o.s1v;
        issue_bus.Src2_Issue_OC       = o.s2;
        issue_bus.Src2_Valid_Issue_OC = o.s2v;
        issue_bus.Dst_Issue_OC        = o.dst;
        issue_bus.Imme_Issue_OC       = o.imm;
        issue_bus.Imme_Valid_Issue_OC = o.immv;
        issue_bus.RegWrite_Issue_OC   = o.regw;
        issue_bus.ALUop_Issue_OC      = o.aluop;
        issue_bus.BEQ_Issue_OC        = o.beq;
        issue_bus.BLT_Issue_OC        = o.blt;
        issue_bus.ScbID_Issue_OC      = o.scb;
    endtask

    // Presents one op, waits (bounded) for acceptance, queues its expectation.
    task automatic issue_op(input op_t o, input int delay, output int xfer);
        int n;
        n = 0;
        @(negedge clk);
        drive_op(o);
        grant_delay = delay;
        issue_bus.Valid_Issue_OC = 1'b1;
        while (!issue_bus.Ready_OC_Issue && n < 50) begin
            @(negedge clk);
            n++;
        end
        sb.push_back(expect_of(o, delay));
        @(posedge clk);
        #1;
        xfer = cyc;
        issue_bus.Valid_Issue_OC = 1'b0;
    endtask

    task automatic wait_valid(output int at);
        at = -1000;
        for (int n = 0; n < 60; n++) begin
            @(posedge clk);
            #1;
            if (alu_bus.Valid_OC_ALU) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        issue_bus.Valid_Issue_OC = 1'b0;
        drive_op('{default: '0});
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (alu_bus.Valid_OC_ALU !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", alu_bus.Valid_OC_ALU); end
        total++; if (rf_bus.Req_OC_RF !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", rf_bus.Req_OC_RF); end
        total++; if (dut_ctrl() !== 74'd0) begin bad++; $display("FAIL reset_ctrl: got %h want 0", dut_ctrl()); end
        total++; if ({alu_bus.Src1_Data_OC_ALU, alu_bus.Src2_Data_OC_ALU} !== 512'd0) begin bad++; $display("FAIL reset_data: got nonzero want 0"); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        total++; if (issue_bus.Ready_OC_Issue !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", issue_bus.Ready_OC_Issue); end
    endtask

    task automatic test_one_read();
        op_t o; txn_t t; int xfer; int at;
        simple_data = 1'b1;
        req_addr_log.delete();
        o = rand_op();
        o.s1 = 5'd3; o.s1v = 1'b1; o.s2 = 5'd6; o.s2v = 1'b0; o.imm = 16'h0010; o.immv = 1'b1;
        issue_op(o, 0, xfer);
        wait_valid(at);
        t = sb.pop_front();
        total++; if (at - xfer != t.lat || t.lat != 3) begin bad++; $display("FAIL one_read_latency: got %0d want 3", at - xfer); end
        total++; if (alu_bus.Src1_Data_OC_ALU !== t.d1) begin bad++; $display("FAIL one_read_src1: got %h want %h", alu_bus.Src1_Data_OC_ALU, t.d1); end
        total++; if (alu_bus.Src1_Data_OC_ALU[5*32 +: 32] !== 32'd5) begin bad++; $display("FAIL one_read_lane5: got %h want 5", alu_bus.Src1_Data_OC_ALU[5*32 +: 32]); end
        total++; if (alu_bus.Src2_Data_OC_ALU !== 256'd0) begin bad++; $display("FAIL one_read_src2: got %h want 0", alu_bus.Src2_Data_OC_ALU); end
        total++; if (dut_ctrl() !== exp_ctrl(t.o)) begin bad++; $display("FAIL one_read_ctrl: got %h want %h", dut_ctrl(), exp_ctrl(t.o)); end
        total++; if (alu_bus.Imme_OC_ALU !== 16'h0010) begin bad++; $display("FAIL one_read_imme: got %h want 0010", alu_bus.Imme_OC_ALU); end
        total++; if (req_addr_log.size() != 1 || req_addr_log[0] !== 5'd3) begin bad++; $display("FAIL one_read_reqs: got %0d reqs want 1 to R3", req_addr_log.size()); end
        @(posedge clk);
        #1;
        total++; if (alu_bus.Valid_OC_ALU !== 1'b0) begin bad++; $display("FAIL one_read_pulse: got %b want 0", alu_bus.Valid_OC_ALU); end
        total++; if (alu_bus.Src1_Data_OC_ALU !== t.d1 || dut_ctrl() !== exp_ctrl(t.o)) begin bad++; $display("FAIL one_read_hold: got %h want %h", dut_ctrl(), exp_ctrl(t.o)); end
        simple_data = 1'b0;
    endtask

    task automatic test_grant_stall();
        op_t o; txn_t t; int xfer; int at; logic [4:0] got[6]; logic [4:0] want[6];
        req_addr_log.delete();
        o = rand_op();
        o.w = 3'd2; o.s1 = 5'd1; o.s1v = 1'b1; o.s2 = 5'd2; o.s2v = 1'b1;
        issue_op(o, 4, xfer);
        wait_valid(at);
        t = sb.pop_front();
        total++; if (at - xfer != t.lat || t.lat != 9) begin bad++; $display("FAIL stall_latency: got %0d want 9", at - xfer); end
        want = '{5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd2};
        got  = '{default: '0};
        for (int i = 0; i < 6 && i < req_addr_log.size(); i++) got[i] = req_addr_log[i];
        total++; if (req_addr_log.size() != 6 || got != want) begin bad++; $display("FAIL stall_addr_seq: got %0d reqs %h/%h want 5x R1 then R2", req_addr_log.size(), got[4], got[5]); end
        total++; if (alu_bus.Src1_Data_OC_ALU !== t.d1 || alu_bus.Src2_Data_OC_ALU !== t.d2) begin bad++; $display("FAIL stall_data: got %h want %h", alu_bus.Src2_Data_OC_ALU, t.d2); end
    endtask

    task automatic test_zero_reg();
        op_t o; txn_t t; int xfer; int at;
        req_addr_log.delete();
        o = rand_op();
        o.s1 = 5'd0; o.s1v = 1'b1; o.s2 = 5'd0; o.s2v = 1'b1;
        issue_op(o, 0, xfer);
        wait_valid(at);
        t = sb.pop_front();
        total++; if (at - xfer != 1) begin bad++; $display("FAIL zero_latency: got %0d want 1", at - xfer); end
        total++; if (req_addr_log.size() != 0) begin bad++; $display("FAIL zero_reqs: got %0d want 0", req_addr_log.size()); end
        total++; if ({alu_bus.Src1_Data_OC_ALU, alu_bus.Src2_Data_OC_ALU} !== {t.d1, t.d2}) begin bad++; $display("FAIL zero_data: got %h want 0", alu_bus.Src1_Data_OC_ALU); end
        total++; if (dut_ctrl() !== exp_ctrl(t.o)) begin bad++; $display("FAIL zero_ctrl: got %h want %h", dut_ctrl(), exp_ctrl(t.o)); end
    endtask

    task automatic test_ctrl_fields();
        op_t o; txn_t t; int xfer; int at; bit warp_ok;
        req_warp_log.delete();
        o = rand_op();
        o.w = 3'd5; o.beq = 1'b1; o.scb = 2'b10; o.s1 = 5'd4; o.s1v = 1'b1; o.s2 = 5'd9; o.s2v = 1'b1;
        issue_op(o, 0, xfer);
        wait_valid(at);
        t = sb.pop_front();
        total++; if (at - xfer != 5) begin bad++; $display("FAIL ctrl_latency: got %0d want 5", at - xfer); end
        total++; if ({alu_bus.BEQ_OC_ALU, alu_bus.ScbID_OC_ALU, alu_bus.WarpID_OC_ALU} !== {1'b1, 2'b10, 3'd5}) begin bad++; $display("FAIL ctrl_fields: got %b want 1105", {alu_bus.BEQ_OC_ALU, alu_bus.ScbID_OC_ALU, alu_bus.WarpID_OC_ALU}); end
        total++; if (dut_ctrl() !== exp_ctrl(t.o) || alu_bus.Src2_Data_OC_ALU !== t.d2) begin bad++; $display("FAIL ctrl_entry: got %h want %h", dut_ctrl(), exp_ctrl(t.o)); end
        warp_ok = (req_warp_log.size() == 2);
        foreach (req_warp_log[i]) if (req_warp_log[i] !== 3'd5) warp_ok = 1'b0;
        total++; if (!warp_ok) begin bad++; $display("FAIL ctrl_rf_warp: got %0d reqs want 2 with warp 5", req_warp_log.size()); end
        @(posedge clk);
        #1;
        total++; if (alu_bus.Valid_OC_ALU !== 1'b0) begin bad++; $display("FAIL ctrl_pulse: got %b want 0", alu_bus.Valid_OC_ALU); end
    endtask

    task automatic test_src2_only();
        op_t o; txn_t t; int xfer; int at;
        req_addr_log.delete();
        o = rand_op();
        o.s1 = 5'd7; o.s1v = 1'b0; o.s2 = 5'd9; o.s2v = 1'b1; o.immv = 1'b1;
        issue_op(o, 0, xfer);
        wait_valid(at);
        t = sb.pop_front();
        total++; if (at - xfer != 3) begin bad++; $display("FAIL src2_latency: got %0d want 3", at - xfer); end
        total++; if (req_addr_log.size() != 1 || req_addr_log[0] !== 5'd9) begin bad++; $display("FAIL src2_reqs: got %0d reqs want 1 to R9", req_addr_log.size()); end
        total++; if (alu_bus.Src1_Data_OC_ALU !== t.d1 || alu_bus.Src2_Data_OC_ALU !== t.d2) begin bad++; $display("FAIL src2_data: got %h want %h", alu_bus.Src2_Data_OC_ALU, t.d2); end
    endtask

    task automatic test_reset_mid();
        op_t o; int xfer; bit quiet;
        req_addr_log.delete();
        o = rand_op();
        o.s1 = 5'd8; o.s1v = 1'b1; o.s2 = 5'd10; o.s2v = 1'b1;
        issue_op(o, 0, xfer);
        void'(sb.pop_front());
        @(posedge clk);
        #2;
        total++; if (req_addr_log.size() != 1 || rf_bus.Req_OC_RF !== 1'b0) begin bad++; $display("FAIL mid_in_cap1: got %0d reqs want 1 and idle port", req_addr_log.size()); end
        rst = 1'b0;
        #1;
        total++; if (rf_bus.Req_OC_RF !== 1'b0 || alu_bus.Valid_OC_ALU !== 1'b0) begin bad++; $display("FAIL mid_reset_outputs: got req %b valid %b want 0 0", rf_bus.Req_OC_RF, alu_bus.Valid_OC_ALU); end
        total++; if (alu_bus.Src1_Data_OC_ALU !== 256'd0 || dut_ctrl() !== 74'd0) begin bad++; $display("FAIL mid_reset_clear: got %h want 0", dut_ctrl()); end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        total++; if (issue_bus.Ready_OC_Issue !== 1'b1) begin bad++; $display("FAIL mid_ready: got %b want 1", issue_bus.Ready_OC_Issue); end
        quiet = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (alu_bus.Valid_OC_ALU !== 1'b0 || rf_bus.Req_OC_RF !== 1'b0) quiet = 1'b0;
            @(posedge clk);
            #1;
        end
        total++; if (!quiet || req_addr_log.size() != 1) begin bad++; $display("FAIL mid_abandon: got dispatch/request after reset want none"); end
    endtask

    task automatic test_back_to_back();
        op_t ops[4]; txn_t t; int idx; int nd; int first_x; int last; bit rdy;
        idx = 0; nd = 0; first_x = -1; last = -1;
        for (int i = 0; i < 4; i++) begin
            ops[i] = rand_op();
            ops[i].s1v = 1'b0;
            ops[i].s2 = 5'd0;
        end
        @(negedge clk);
        drive_op(ops[0]);
        issue_bus.Valid_Issue_OC = 1'b1;
        for (int n = 0; n < 40 && nd < 4; n++) begin
            rdy = issue_bus.Ready_OC_Issue;
            @(posedge clk);
            #1;
            if (rdy && idx < 4) begin
                sb.push_back(expect_of(ops[idx], 0));
                if (first_x < 0) first_x = cyc;
                idx++;
                if (idx < 4) drive_op(ops[idx]);
                else issue_bus.Valid_Issue_OC = 1'b0;
            end
            if (alu_bus.Valid_OC_ALU) begin
                t = sb.pop_front();
                total++; if (dut_ctrl() !== exp_ctrl(t.o)) begin bad++; $display("FAIL b2b_fields[%0d]: got %h want %h", nd, dut_ctrl(), exp_ctrl(t.o)); end
                total++; if (cyc != first_x + 1 + 2 * nd) begin bad++; $display("FAIL b2b_timing[%0d]: got cycle %0d want %0d (prev %0d)", nd, cyc, first_x + 1 + 2 * nd, last); end
                last = cyc;
                nd++;
            end
            @(negedge clk);
        end
        issue_bus.Valid_Issue_OC = 1'b0;
        total++; if (nd != 4) begin bad++; $display("FAIL b2b_count: got %0d dispatches want 4", nd); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_one_read();
        test_grant_stall();
        test_zero_reg();
        test_ctrl_fields();
        test_src2_only();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
